dmem_port_arbiter: RTL and testbench

Arbitrates the single data-memory port between the pipeline MEM stage (CPU) and a block-transfer requester (DMA/loader). It drives the data memory's address, write-data and write-enable inputs, and returns read data to whichever side owns the port. CPU accesses pass through with zero added latency. The DMA side gets bounded bursts, and a starvation counter guarantees it progress.

---
 rtl/dmem_port_arbiter.sv | 101 ++++++++++
 tb/tb_dmem_port_arbiter.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/dmem_port_arbiter.sv
// Shares the single data-memory port between the CPU MEM stage and a block-transfer (DMA) requester.
// CPU accesses pass straight through; DMA bursts are bounded, and a wait counter forces DMA in when the CPU keeps the port busy.
//
// state   | meaning
// --------+------------------------------------------------------------
// ST_CPU  | CPU drives the port; wait_cnt counts cycles the DMA was held off
// ST_DMA  | DMA drives the port; burst_cnt counts acks in this grant
module dmem_port_arbiter #(
  parameter int MAX_BURST    = 8,
  parameter int STARVE_LIMIT = 4
) (
  input  logic        clock,
  input  logic        clr,
  input  logic        cpu_req,
  input  logic        cpu_we,
  input  logic [31:0] cpu_addr,
  input  logic [31:0] cpu_wdata,
  output logic [31:0] cpu_rdata,
  output logic        cpu_stall,
  input  logic        dma_req,
  input  logic        dma_we,
  input  logic [31:0] dma_addr,
  input  logic [31:0] dma_wdata,
  output logic [31:0] dma_rdata,
  output logic        dma_ack,
  output logic        dma_gnt,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_datain,
  output logic        mem_we,
  input  logic [31:0] mem_dataout
);

  localparam int WW = (STARVE_LIMIT > 1) ? $clog2(STARVE_LIMIT) : 1;
  localparam int BW = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;
  localparam logic [WW-1:0] WAIT_LAST  = WW'(STARVE_LIMIT - 1);
  localparam logic [BW-1:0] BURST_LAST = BW'(MAX_BURST - 1);

  typedef enum logic {ST_CPU, ST_DMA} state_t;

  state_t        state, state_nxt;
  logic [WW-1:0] wait_cnt, wait_nxt;
  logic [BW-1:0] burst_cnt, burst_nxt;

  always_ff @(posedge clock) begin
    if (clr) begin
      state     <= ST_CPU;
      wait_cnt  <= '0;
      burst_cnt <= '0;
    end else begin
      state     <= state_nxt;
      wait_cnt  <= wait_nxt;
      burst_cnt <= burst_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    wait_nxt   = wait_cnt;
    burst_nxt  = burst_cnt;
    mem_addr   = cpu_addr;
    mem_datain = cpu_wdata;
    mem_we     = 1'b0;
    cpu_stall  = 1'b0;
    dma_ack    = 1'b0;
    dma_gnt    = 1'b0;
    case (state)
      ST_CPU: begin
        mem_we = cpu_req & cpu_we;
        if (dma_req && cpu_req && (wait_cnt != WAIT_LAST))
          wait_nxt = wait_cnt + 1'b1;
        // CPU is still served this cycle; the DMA owns the port from the next edge
        if (dma_req && (!cpu_req || (wait_cnt == WAIT_LAST))) begin
          state_nxt = ST_DMA;
          wait_nxt  = '0;
          burst_nxt = '0;
        end
      end
      ST_DMA: begin
        mem_addr   = dma_addr;
        mem_datain = dma_wdata;
        mem_we     = dma_req & dma_we;
        dma_ack    = dma_req;
        dma_gnt    = 1'b1;
        cpu_stall  = cpu_req;
        if (dma_req)
          burst_nxt = (burst_cnt == BURST_LAST) ? '0 : burst_cnt + 1'b1;
        // Yield only to a waiting CPU; an uncontested DMA keeps the port
        if (!dma_req || (cpu_req && (burst_cnt == BURST_LAST))) begin
          state_nxt = ST_CPU;
          wait_nxt  = '0;
          burst_nxt = '0;
        end
      end
      default: state_nxt = ST_CPU;
    endcase
  end

  assign cpu_rdata = mem_dataout;
  assign dma_rdata = mem_dataout;

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Directed bench for dmem_port_arbiter with a small behavioural data memory behind the port.
module tb_dmem_port_arbiter;

  logic        clock = 1'b0;
  logic        clr;
  logic        cpu_req, cpu_we;
  logic [31:0] cpu_addr, cpu_wdata, cpu_rdata;
  logic        cpu_stall;
  logic        dma_req, dma_we;
  logic [31:0] dma_addr, dma_wdata, dma_rdata;
  logic        dma_ack, dma_gnt;
  logic [31:0] mem_addr, mem_datain, mem_dataout;
  logic        mem_we;

  logic [31:0] tb_mem [0:255];

  int n_checks = 0;
  int n_errors = 0;
  int acks;

  always #5 clock = ~clock;

  always @(posedge clock)
    if (mem_we) tb_mem[mem_addr[9:2]] <= mem_datain;

  assign mem_dataout = tb_mem[mem_addr[9:2]];

  dmem_port_arbiter dut (
    .clock(clock), .clr(clr),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall),
    .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
    .dma_rdata(dma_rdata), .dma_ack(dma_ack), .dma_gnt(dma_gnt),
    .mem_addr(mem_addr), .mem_datain(mem_datain), .mem_we(mem_we), .mem_dataout(mem_dataout)
  );

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Inputs change 1 time unit after the rising edge; outputs are sampled 2 units later.
  task automatic cycle_start();
    @(posedge clock);
    #1;
  endtask

  task automatic settle();
    #2;
  endtask

  initial begin
    clr = 1'b1;
    cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
    dma_req = 1'b0; dma_we = 1'b0; dma_addr = '0; dma_wdata = '0;

    // Reset state
    cycle_start();
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 32'h0000_0030; cpu_wdata = 32'h1234_5678;
    settle();
    check_eq("rst_gnt", dma_gnt, 0);
    check_eq("rst_ack", dma_ack, 0);
    check_eq("rst_stall", cpu_stall, 0);
    check_eq("rst_mem_we", mem_we, 1);

    // CPU-only write then read
    cycle_start();
    clr = 1'b0;
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 32'h10; cpu_wdata = 32'hA5A5_A5A5;
    settle();
    check_eq("cpu_wr_we", mem_we, 1);
    check_eq("cpu_wr_stall", cpu_stall, 0);
    check_eq("cpu_wr_addr", mem_addr, 32'h10);
    check_eq("cpu_wr_data", mem_datain, 32'hA5A5_A5A5);
    cycle_start();
    cpu_we = 1'b0;
    settle();
    check_eq("cpu_rd_we", mem_we, 0);
    check_eq("cpu_rd_data", cpu_rdata, 32'hA5A5_A5A5);

    // DMA-only: three writes to 0x0, 0x4, 0x8
    acks = 0;
    for (int c = 0; c < 6; c++) begin
      cycle_start();
      cpu_req = 1'b0; cpu_we = 1'b0;
      dma_req = (acks < 3); dma_we = 1'b1;
      dma_addr = 32'(4 * acks); dma_wdata = 32'hD0 + 32'(acks);
      settle();
      check_eq($sformatf("dma3_gnt_c%0d", c), dma_gnt, (c >= 1 && c <= 4));
      check_eq($sformatf("dma3_ack_c%0d", c), dma_ack, (c >= 1 && c <= 3));
      check_eq($sformatf("dma3_we_c%0d", c), mem_we, (c >= 1 && c <= 3));
      if (c >= 1 && c <= 3) check_eq($sformatf("dma3_addr_c%0d", c), mem_addr, 32'(4 * (c - 1)));
      if (dma_ack) acks++;
    end
    cycle_start();
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h4;
    settle();
    check_eq("dma3_readback", cpu_rdata, 32'hD1);
    check_eq("dma3_rdata_mirror", dma_rdata, 32'hD1);

    // Starvation with defaults: CPU 4 cycles, DMA 8 acks, repeating; 20 DMA words
    acks = 0;
    for (int c = 0; c < 34; c++) begin
      cycle_start();
      cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h40;
      dma_req = (acks < 20); dma_we = 1'b0; dma_addr = 32'h80;
      settle();
      check_eq($sformatf("starve_stall_c%0d", c), cpu_stall, (c < 32) ? ((c % 12) >= 4) : (c == 32));
      check_eq($sformatf("starve_ack_c%0d", c), dma_ack, (c < 32) && ((c % 12) >= 4));
      if (dma_ack) acks++;
    end
    check_eq("starve_total_acks", acks, 20);

    // Burst wrap, no CPU: 12 consecutive acks, then idle cycle, then CPU state
    acks = 0;
    for (int c = 0; c < 15; c++) begin
      cycle_start();
      cpu_req = 1'b0;
      dma_req = (acks < 12); dma_we = 1'b1;
      dma_addr = 32'h100 + 32'(4 * acks); dma_wdata = 32'(acks);
      settle();
      check_eq($sformatf("wrap_ack_c%0d", c), dma_ack, (c >= 1 && c <= 12));
      check_eq($sformatf("wrap_gnt_c%0d", c), dma_gnt, (c >= 1 && c <= 13));
      if (dma_ack) acks++;
    end

    // Burst wrap with CPU raised at word 5: yields after the burst_cnt==7 ack
    acks = 0;
    for (int c = 0; c < 17; c++) begin
      cycle_start();
      cpu_req = (c >= 6 && c <= 9); cpu_we = 1'b0; cpu_addr = 32'h10;
      dma_req = (acks < 12); dma_we = 1'b1;
      dma_addr = 32'h100 + 32'(4 * acks); dma_wdata = 32'(acks);
      settle();
      check_eq($sformatf("yield_ack_c%0d", c), dma_ack, (c >= 1 && c <= 8) || (c >= 11 && c <= 14));
      check_eq($sformatf("yield_stall_c%0d", c), cpu_stall, (c >= 6 && c <= 8));
      check_eq($sformatf("yield_gnt_c%0d", c), dma_gnt, (c >= 1 && c <= 8) || (c >= 11 && c <= 15));
      if (c == 9) check_eq("yield_cpu_rdata", cpu_rdata, 32'hA5A5_A5A5);
      if (dma_ack) acks++;
    end

    // DMA with a gap: one ack, then dma_req drops while the CPU wants to write
    cycle_start();
    cpu_req = 1'b0; dma_req = 1'b1; dma_we = 1'b0; dma_addr = 32'h8;
    settle();
    check_eq("gap_c0_ack", dma_ack, 0);
    cycle_start();
    settle();
    check_eq("gap_c1_ack", dma_ack, 1);
    check_eq("gap_c1_rdata", dma_rdata, 32'hD2);
    cycle_start();
    dma_req = 1'b0; cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 32'h20; cpu_wdata = 32'hCAFE_0001;
    settle();
    check_eq("gap_idle_stall", cpu_stall, 1);
    check_eq("gap_idle_we", mem_we, 0);
    check_eq("gap_idle_ack", dma_ack, 0);
    cycle_start();
    settle();
    check_eq("gap_cpu_stall", cpu_stall, 0);
    check_eq("gap_cpu_we", mem_we, 1);
    check_eq("gap_cpu_addr", mem_addr, 32'h20);

    // Reset during an active DMA burst
    cycle_start();
    cpu_req = 1'b0; cpu_we = 1'b0; dma_req = 1'b1; dma_we = 1'b0; dma_addr = 32'h0;
    cycle_start();
    settle();
    check_eq("rstb_pre_gnt", dma_gnt, 1);
    cycle_start();
    clr = 1'b1; cpu_req = 1'b1; cpu_addr = 32'h40;
    cycle_start();
    settle();
    check_eq("rstb_mid_gnt", dma_gnt, 0);
    cycle_start();
    clr = 1'b0; dma_req = 1'b0;
    settle();
    check_eq("rstb_gnt", dma_gnt, 0);
    check_eq("rstb_stall", cpu_stall, 0);
    check_eq("rstb_ack", dma_ack, 0);
    check_eq("rstb_addr", mem_addr, 32'h40);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
